fp_reduce_seq: RTL and testbench

FP_REDUCE_SEQ -- requirements
Module: fp_reduce_seq

---
 rtl/fp_reduce_seq_pkg.sv | 13 +
 rtl/fp_reduce_seq.sv | 93 +++++++++
 tb/tb_fp_reduce_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_reduce_seq_pkg.sv
// Shared vector-unit definitions: reduction FSM states and default sizing.
package fp_reduce_seq_pkg;

  localparam int unsigned FPR_MAX_VL_DEF = 32;
  localparam int unsigned FPR_DW_DEF     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fpr_state_e;

endpackage

// File: rtl/fp_reduce_seq.sv
// Sequential FP add/sub reduction: folds a stream of elements into an accumulator
// through an external combinational adder, then presents the result on a handshake.
module fp_reduce_seq
  import fp_reduce_seq_pkg::*;
#(
  parameter  int unsigned MAX_VL = FPR_MAX_VL_DEF,
  parameter  int unsigned DW     = FPR_DW_DEF,
  localparam int unsigned CW     = $clog2(MAX_VL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [CW-1:0] vl_i,
  input  logic          op_sub_i,
  input  logic [DW-1:0] init_i,
  input  logic          abort_i,
  input  logic          elem_valid_i,
  input  logic [DW-1:0] elem_data_i,
  output logic          elem_ready_o,
  output logic [DW-1:0] add_a_o,
  output logic [DW-1:0] add_b_o,
  output logic          add_sub_o,
  input  logic [DW-1:0] add_y_i,
  output logic          res_valid_o,
  output logic [DW-1:0] res_data_o,
  input  logic          res_ready_i,
  output logic          busy_o
);

  fpr_state_e    state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] vl_q, vl_d;
  logic          sub_q, sub_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      vl_q    <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      vl_q    <= vl_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    vl_d    = vl_q;
    sub_d   = sub_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          vl_d    = (vl_i > CW'(MAX_VL)) ? CW'(MAX_VL) : vl_i;
          sub_d   = op_sub_i;
          acc_d   = init_i;
          cnt_d   = '0;
          state_d = (vl_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // abort wins over a simultaneous transfer
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (elem_valid_i) begin
          acc_d = add_y_i;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == vl_q - CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort_i || res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign elem_ready_o = (state_q == ST_RUN);
  assign res_valid_o  = (state_q == ST_DONE);
  assign busy_o       = (state_q != ST_IDLE);
  assign res_data_o   = acc_q;
  assign add_a_o      = acc_q;
  assign add_b_o      = elem_data_i;
  assign add_sub_o    = sub_q;

endmodule

// File: tb/tb_fp_reduce_seq.sv
// Bench for fp_reduce_seq: supplies the combinational FP adder and checks results
// against fixed vectors and a fold-based reference over randomized commands.
module tb_fp_reduce_seq;
  localparam int MAXV = 8;
  localparam int VW   = $clog2(MAXV + 1);

  logic          clk, rst_n;
  logic          start, op_sub, abort, elem_valid, res_ready;
  logic [VW-1:0] vl;
  logic [31:0]   init, elem_data, add_a, add_b, add_y, res_data;
  logic          elem_ready, add_sub, res_valid, busy;

  int n_chk = 0;
  int n_fail = 0;

  fp_reduce_seq #(.MAX_VL(MAXV), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .vl_i(vl), .op_sub_i(op_sub),
    .init_i(init), .abort_i(abort), .elem_valid_i(elem_valid), .elem_data_i(elem_data),
    .elem_ready_o(elem_ready), .add_a_o(add_a), .add_b_o(add_b), .add_sub_o(add_sub),
    .add_y_i(add_y), .res_valid_o(res_valid), .res_data_o(res_data),
    .res_ready_i(res_ready), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single precision <-> real, normal numbers and zero only
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int es;
    logic [24:0] mt;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    es = int'(d[62:52]) - 1023 + 127;
    mt = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || mt[0])) mt = mt + 25'd1;
    if (mt[24]) begin mt = mt >> 1; es++; end
    return {d[63], es[7:0], mt[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
    return r2f(s ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  assign add_y = fadd(add_a, add_b, add_sub);

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'(125 + $urandom_range(0, 4)), 23'($urandom)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one command, stream n elements, then drain the result.
  task automatic do_cmd(input string tag, input logic [31:0] ini, input int vl_in, input bit sub,
                        input int n, input logic [31:0] el [16], input logic [31:0] exp,
                        input int gap_pct, input int rr_hold, input bit spam);
    int k, cyc;
    bit saw_rdy, done;
    logic [31:0] held;
    k = 0; cyc = 0; saw_rdy = 0; done = 0;
    @(negedge clk);
    start = 1'b1; vl = VW'(vl_in); op_sub = sub; init = ini;
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    while (!done && cyc < 300) begin
      if (res_valid) done = 1;
      else begin
        if (elem_ready) saw_rdy = 1;
        elem_valid = elem_ready && ($urandom_range(99) >= 32'(gap_pct));
        elem_data  = el[k & 15];
        if (spam && busy) begin
          start = 1'b1; vl = VW'($urandom_range(0, 15)); init = $urandom; op_sub = ~sub;
        end
        @(negedge clk);
        cyc++;
        if (elem_valid) k++;
        elem_valid = 1'b0; start = 1'b0;
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " res"}, res_data, exp);
    chk({tag, " count"}, 32'(k), 32'(n));
    chk({tag, " saw_ready"}, 32'(saw_rdy), 32'(n > 0));
    if (gap_pct == 0) chk({tag, " latency"}, 32'(cyc), 32'(n + 1));
    held = res_data;
    for (int i = 0; i < rr_hold; i++) begin
      if (spam) begin start = 1'b1; vl = VW'(1); end
      @(negedge clk);
      start = 1'b0;
      chk({tag, " hold valid"}, 32'(res_valid), 32'd1);
      chk({tag, " hold data"}, res_data, held);
    end
    res_ready = 1'b1; start = spam; vl = VW'(1);
    @(negedge clk);
    res_ready = 1'b0; start = 1'b0;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle res_valid"}, 32'(res_valid), 32'd0);
  endtask

  typedef struct packed {
    logic [31:0]       init;
    logic [3:0]        vl;
    logic              sub;
    logic [3:0][31:0]  el;
    logic [31:0]       exp;
  } vec_t;

  initial begin
    vec_t tbl [4];
    logic [31:0] el [16];
    logic [31:0] exp;
    int v, n;
    bit s;
    logic [31:0] ini;

    tbl[0] = '{init: 32'h3F800000, vl: 4'd3, sub: 1'b0,
               el: {32'h0, 32'h3F800000, 32'h3F800000, 32'h3F800000}, exp: 32'h40800000};
    tbl[1] = '{init: 32'h41200000, vl: 4'd2, sub: 1'b1,
               el: {32'h0, 32'h0, 32'h40400000, 32'h40000000}, exp: 32'h40A00000};
    tbl[2] = '{init: 32'h12345678, vl: 4'd0, sub: 1'b0, el: '0, exp: 32'h12345678};
    tbl[3] = '{init: 32'h00000000, vl: 4'd4, sub: 1'b0,
               el: {32'hBF800000, 32'h40000000, 32'h3E800000, 32'h3F000000}, exp: 32'h3FE00000};

    rst_n = 1'b0; start = 1'b0; vl = '0; op_sub = 1'b0; init = '0; abort = 1'b0;
    elem_valid = 1'b0; elem_data = '0; res_ready = 1'b0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst elem_ready", 32'(elem_ready), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_data", res_data, 32'd0);
    chk("rst add_sub", 32'(add_sub), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) el[i] = (i < 4) ? tbl[t].el[i] : 32'h0;
      do_cmd($sformatf("vec%0d", t), tbl[t].init, int'(tbl[t].vl), tbl[t].sub,
             int'(tbl[t].vl), el, tbl[t].exp, 0, 0, 1'b0);
    end

    // vl above MAX_VL clamps: eight 1.0 elements from 0 give 8.0
    for (int i = 0; i < 16; i++) el[i] = 32'h3F800000;
    do_cmd("clamp", 32'h0, 15, 1'b0, MAXV, el, 32'h41000000, 0, 0, 1'b0);

    // stalls, delayed res_ready, start pulses while busy (including with res_ready)
    for (int i = 0; i < 16; i++) el[i] = (i < 3) ? 32'h3F800000 : 32'h0;
    do_cmd("stall", 32'h3F800000, 3, 1'b0, 3, el, 32'h40800000, 50, 5, 1'b1);

    // abort after 2 of 4: the abort-cycle element must not be absorbed
    for (int i = 0; i < 16; i++) el[i] = 32'h3F800000;
    @(negedge clk);
    start = 1'b1; vl = VW'(4); op_sub = 1'b0; init = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      elem_valid = 1'b1; elem_data = 32'h3F800000;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; elem_valid = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort elem_ready", 32'(elem_ready), 32'd0);
    chk("abort acc", res_data, 32'h40000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no res_valid", 32'(res_valid), 32'd0);
    end
    do_cmd("post_abort", 32'h40400000, 2, 1'b1, 2, el, 32'h3F800000, 0, 0, 1'b0);

    // abort beats res_ready in DONE; abort in IDLE does not block start
    @(negedge clk);
    start = 1'b1; abort = 1'b1; vl = '0; init = 32'h40400000;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle abort noop", 32'(res_valid), 32'd1);
    abort = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; res_ready = 1'b0;
    chk("done abort", 32'(busy), 32'd0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; vl = VW'(4); op_sub = 1'b0; init = 32'h3F800000;
    @(negedge clk);
    start = 1'b0; elem_valid = 1'b1; elem_data = 32'h3F800000;
    @(negedge clk);
    elem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst elem_ready", 32'(elem_ready), 32'd0);
    chk("arst res_valid", 32'(res_valid), 32'd0);
    chk("arst res_data", res_data, 32'd0);
    chk("arst add_a", add_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst idle", 32'(busy), 32'd0);
    do_cmd("post_rst", 32'h3F800000, 3, 1'b0, 3, el, 32'h40800000, 0, 0, 1'b0);

    // randomized commands against a fold of the reduction rule
    for (int t = 0; t < 20; t++) begin
      v   = (t % 5 == 4) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, MAXV));
      n   = (v > MAXV) ? MAXV : v;
      s   = 1'($urandom);
      ini = rnd_f();
      for (int i = 0; i < 16; i++) el[i] = rnd_f();
      exp = ini;
      for (int i = 0; i < n; i++) exp = fadd(exp, el[i], s);
      do_cmd($sformatf("rnd%0d", t), ini, v, s, n, el, exp,
             (t % 2 == 0) ? 0 : 40, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
